strb_sender: RTL

Strobe-stream transmitter: on a start command it walks a 32-entry × 8-bit source register bank and emits bytes one per STRB_VALID pulse, with a programmable idle gap between strobes. It is the sending end of the STRB_DATA/STRB_VALID byte-strobe interface. The downstream capture block indexes its 32-entry output bank with its own 5-bit strobe counter, so this block always starts a transfer at index 0. The block drives test stimulus into the capture path and produces self-generated strobe traffic.

---
 rtl/strb_pkg.sv | 21 ++
 rtl/strb_gap_timer.sv | 36 +++
 rtl/strb_sender.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/strb_pkg.sv
// Shared types and sizes for the byte-strobe transmitter.
package strb_pkg;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 8;
  localparam int unsigned GAP_W = 4;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // One strobed beat: the byte and the bank index it came from.
  typedef struct packed {
    logic [IDX_W-1:0] cnt;
    logic [DW-1:0]    data;
  } strb_beat_t;

endpackage

// File: rtl/strb_gap_timer.sv
// Loadable down-counter that paces the idle cycles between strobes.
module strb_gap_timer
  import strb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_c
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Final gap cycle: the next edge launches the following strobe.
  assign last_c = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/strb_sender.sv
// Byte-strobe transmitter: walks the source bank from index 0 and emits one
// byte per STRB_VALID pulse with a programmable idle gap between strobes.
module strb_sender
  import strb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [IDX_W-1:0] len_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             abort_i,
  input  logic [DW-1:0]    in_reg_i [DEPTH],
  output logic [DW-1:0]    strb_data_o,
  output logic             strb_valid_o,
  output logic [IDX_W-1:0] strb_cnts_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  strb_beat_t       beat_q, beat_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_last;
  logic [IDX_W-1:0] idx_inc;

  assign idx_inc = idx_q + IDX_W'(1);

  strb_gap_timer u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (gap_q),
    .dec_i      (tmr_dec),
    .last_c     (tmr_last)
  );

  // Outputs are computed for the state being entered, so a strobe is visible
  // in the cycle right after the edge that reads its byte from the bank.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d     = SEND;
          len_d       = len_i;
          gap_d       = gap_i;
          idx_d       = '0;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          beat_d.cnt  = '0;
          beat_d.data = in_reg_i[0];
        end
      end

      SEND: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (idx_q == len_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          idx_d       = idx_inc;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          beat_d.cnt  = idx_inc;
          beat_d.data = in_reg_i[idx_inc];
        end else begin
          state_d  = GAP;
          idx_d    = idx_inc;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end

      GAP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (tmr_last) begin
          state_d     = SEND;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          beat_d.cnt  = idx_q;
          beat_d.data = in_reg_i[idx_q];
        end else begin
          busy_d  = 1'b1;
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign strb_data_o  = beat_q.data;
  assign strb_cnts_o  = beat_q.cnt;
  assign strb_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
